// File: rtl/mem_stage.sv
// MEM stage: doubleword data memory, branch resolution and MEM/WB register.
// Produces the write-back value consumed by the register file.
module mem_stage #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EM_Branch,
  input  logic        EM_MemRead,
  input  logic        EM_MemWrite,
  input  logic        EM_MemtoReg,
  input  logic        EM_RegWrite,
  input  logic        EM_Zero,
  input  logic        EM_addermuxselect,
  input  logic [4:0]  EM_RD,
  input  logic [63:0] EM_Adder2Out,
  input  logic [63:0] EM_Result,
  input  logic [63:0] EM_WriteData,
  output logic        PCSrc,
  output logic [63:0] BranchTarget,
  output logic        Flush,
  output logic        MW_RegWrite,
  output logic        MW_MemtoReg,
  output logic [4:0]  MW_RD,
  output logic [63:0] MW_ReadData,
  output logic [63:0] MW_Result,
  output logic [63:0] WBData,
  output logic        MemErr
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  logic [7:0]        mem_q [MEM_BYTES];
  logic [7:0]        mem_d [MEM_BYTES];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   addr_end;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic              access;
  logic              fault;
  logic [63:0]       rdata;

  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] rdat_q, rdat_d;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;

  // Bound is computed one bit wider so addresses near 2^64 cannot wrap in.
  assign addr     = EM_Result[ADDR_W-1:0];
  assign addr_end = {1'b0, addr} + (ADDR_W+1)'(8);
  assign valid    = (addr[2:0] == 3'b000) &&
                    (addr_end <= (ADDR_W+1)'(MEM_BYTES));
  assign idx      = addr[IDX_W-1:0];
  assign access   = EM_MemRead | EM_MemWrite;
  assign fault    = access & ~valid;

  assign PCSrc        = ~reset & EM_Branch & (EM_Zero ^ EM_addermuxselect);
  assign Flush        = PCSrc;
  assign BranchTarget = EM_Adder2Out;

  // Little-endian read of the addressed doubleword and the store update.
  always_comb begin
    rdata = '0;
    mem_d = mem_q;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem_q[idx + IDX_W'(i)];
    end
    if (EM_MemWrite && valid) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[idx + IDX_W'(i)] = EM_WriteData[8*i +: 8];
      end
    end
  end

  // Next values for the MEM/WB boundary and the sticky fault flag.
  always_comb begin
    rw_d   = EM_RegWrite & (EM_RD != 5'd0) & ~fault;
    m2r_d  = EM_MemtoReg;
    rd_d   = EM_RD;
    rdat_d = (EM_MemRead && valid) ? rdata : 64'd0;
    res_d  = EM_Result;
    err_d  = err_q | fault;
  end

  // Data memory; zeroed by reset, which also discards a coincident store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      rd_q   <= 5'd0;
      rdat_q <= 64'd0;
      res_q  <= 64'd0;
      err_q  <= 1'b0;
    end else begin
      rw_q   <= rw_d;
      m2r_q  <= m2r_d;
      rd_q   <= rd_d;
      rdat_q <= rdat_d;
      res_q  <= res_d;
      err_q  <= err_d;
    end
  end

  assign MW_RegWrite = rw_q;
  assign MW_MemtoReg = m2r_q;
  assign MW_RD       = rd_q;
  assign MW_ReadData = rdat_q;
  assign MW_Result   = res_q;
  assign WBData      = m2r_q ? rdat_q : res_q;
  assign MemErr      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Directed tables and sequences plus random traffic against a byte-array model.
module tb_mem_stage;

  localparam int MB = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        br, mrd, mwr, m2r, rw, z, ams;
  logic [4:0]  rd;
  logic [63:0] tgt, res, wd;
  logic        PCSrc, Flush, MW_RegWrite, MW_MemtoReg, MemErr;
  logic [63:0] BranchTarget, MW_ReadData, MW_Result, WBData;
  logic [4:0]  MW_RD;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mm [MB];
  logic        e_rw, e_m2r, e_err;
  logic [4:0]  e_rd;
  logic [63:0] e_rdat, e_res;

  always #5 clk = ~clk;

  mem_stage #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .EM_Branch(br), .EM_MemRead(mrd), .EM_MemWrite(mwr),
    .EM_MemtoReg(m2r), .EM_RegWrite(rw), .EM_Zero(z),
    .EM_addermuxselect(ams), .EM_RD(rd),
    .EM_Adder2Out(tgt), .EM_Result(res), .EM_WriteData(wd),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush(Flush),
    .MW_RegWrite(MW_RegWrite), .MW_MemtoReg(MW_MemtoReg),
    .MW_RD(MW_RD), .MW_ReadData(MW_ReadData),
    .MW_Result(MW_Result), .WBData(WBData), .MemErr(MemErr)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(bit b, bit r, bit w, bit mr, bit wr, bit zz,
                        bit am, logic [4:0] d, logic [63:0] t,
                        logic [63:0] a, logic [63:0] dat);
    br = b; mrd = r; mwr = w; m2r = mr; rw = wr; z = zz; ams = am;
    rd = d; tgt = t; res = a; wd = dat;
  endtask

  function automatic bit m_valid(logic [63:0] a);
    return (a % 8 == 0) && (a <= 64'(MB - 8));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < MB; i++) mm[i] = 8'h00;
    e_rw = 0; e_m2r = 0; e_err = 0; e_rd = 0; e_rdat = 0; e_res = 0;
  endtask

  // One clock of traffic with the current inputs, checked against the model.
  task automatic cycle();
    bit v, acc;
    logic [63:0] ld;
    int base;
    v = m_valid(res);
    acc = mrd || mwr;
    ld = 0;
    base = int'(res[15:0]);
    if (v) for (int i = 0; i < 8; i++) ld[8*i +: 8] = mm[base + i];
    e_rw   = rw && (rd != 0) && !(acc && !v);
    e_m2r  = m2r;
    e_rd   = rd;
    e_rdat = (mrd && v) ? ld : 64'd0;
    e_res  = res;
    e_err  = e_err || (acc && !v);
    if (mwr && v) for (int i = 0; i < 8; i++) mm[base + i] = wd[8*i +: 8];
    #1;
    chk("pcsrc", PCSrc, 64'(br && (z != ams)));
    chk("flush", Flush, 64'(br && (z != ams)));
    chk("target", BranchTarget, tgt);
    @(posedge clk); #1;
    chk("mw_rw", MW_RegWrite, 64'(e_rw));
    chk("mw_m2r", MW_MemtoReg, 64'(e_m2r));
    chk("mw_rd", MW_RD, 64'(e_rd));
    chk("mw_rdat", MW_ReadData, e_rdat);
    chk("mw_res", MW_Result, e_res);
    chk("wbdata", WBData, e_m2r ? e_rdat : e_res);
    chk("memerr", MemErr, 64'(e_err));
  endtask

  typedef struct {
    logic        b, zz, am;
    logic [63:0] t;
    logic        exp_pc;
  } bvec_t;

  bvec_t bv [6];
  logic [63:0] a;
  int sel;

  initial begin
    bv[0] = '{1'b1, 1'b1, 1'b0, 64'h40, 1'b1};
    bv[1] = '{1'b1, 1'b1, 1'b1, 64'h40, 1'b0};
    bv[2] = '{1'b0, 1'b1, 1'b0, 64'h40, 1'b0};
    bv[3] = '{1'b1, 1'b0, 1'b1, 64'h1234, 1'b1};
    bv[4] = '{1'b1, 1'b0, 1'b0, 64'h88, 1'b0};
    bv[5] = '{1'b0, 1'b0, 1'b1, 64'hffff0000, 1'b0};

    reset = 1'b1;
    set_in(1, 1, 1, 1, 1, 1, 0, 5'd7, 64'h40, 64'h10, 64'hdead);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw", MW_RegWrite, 0);
    chk("rst_m2r", MW_MemtoReg, 0);
    chk("rst_rd", MW_RD, 0);
    chk("rst_rdat", MW_ReadData, 0);
    chk("rst_res", MW_Result, 0);
    chk("rst_wb", WBData, 0);
    chk("rst_err", MemErr, 0);
    chk("rst_pcsrc", PCSrc, 0);
    chk("rst_flush", Flush, 0);
    reset = 1'b0;

    set_in(0, 1, 0, 1, 1, 0, 0, 5'd1, 0, 64'h0, 0);
    cycle();
    chk("rst_ld0", MW_ReadData, 0);

    for (int i = 0; i < 6; i++) begin
      set_in(bv[i].b, 0, 0, 0, 0, bv[i].zz, bv[i].am, 0, bv[i].t, 0, 0);
      #1;
      chk("tbl_pcsrc", PCSrc, 64'(bv[i].exp_pc));
      chk("tbl_flush", Flush, 64'(bv[i].exp_pc));
      chk("tbl_tgt", BranchTarget, bv[i].t);
      cycle();
    end

    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 64'h10, 64'h1122334455667788);
    cycle();
    set_in(0, 1, 0, 1, 1, 0, 0, 5'd5, 0, 64'h10, 0);
    cycle();
    chk("ld10", MW_ReadData, 64'h1122334455667788);
    chk("ld10_wb", WBData, 64'h1122334455667788);
    chk("ld10_rd", MW_RD, 5);
    chk("ld10_rw", MW_RegWrite, 1);
    chk("byte10", dut.mem_q[16], 8'h88);
    chk("byte17", dut.mem_q[23], 8'h11);

    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 64'h13, 64'hffffffffffffffff);
    cycle();
    chk("st13_err", MemErr, 1);
    set_in(0, 1, 0, 1, 1, 0, 0, 5'd5, 0, 64'h10, 0);
    cycle();
    chk("st13_keep", MW_ReadData, 64'h1122334455667788);
    set_in(0, 1, 0, 1, 1, 0, 0, 5'd3, 0, 64'(MB - 4), 0);
    cycle();
    chk("ld1fc_dat", MW_ReadData, 0);
    chk("ld1fc_rw", MW_RegWrite, 0);
    set_in(0, 1, 0, 1, 1, 0, 0, 5'd3, 0, 64'hfffffffffffffff8, 0);
    cycle();
    chk("ldwrap_dat", MW_ReadData, 0);
    chk("ldwrap_rw", MW_RegWrite, 0);

    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 64'h20, 64'haa);
    cycle();
    set_in(0, 1, 1, 1, 1, 0, 0, 5'd9, 0, 64'h20, 64'hbb);
    cycle();
    chk("rbw_old", MW_ReadData, 64'haa);
    set_in(0, 1, 0, 1, 1, 0, 0, 5'd9, 0, 64'h20, 0);
    cycle();
    chk("rbw_new", MW_ReadData, 64'hbb);
    set_in(0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 64'h5a5a, 0);
    cycle();
    chk("x0_rw", MW_RegWrite, 0);
    chk("x0_res", MW_Result, 64'h5a5a);
    chk("x0_wb", WBData, 64'h5a5a);
    chk("err_sticky", MemErr, 1);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70) a = 64'($urandom_range(0, MB / 8 - 1) * 8);
      else if (sel < 80) a = 64'($urandom_range(0, MB - 1));
      else if (sel < 90) a = 64'(MB - 16 + $urandom_range(0, 31));
      else a = {$urandom, $urandom};
      if (sel == 99) begin
        reset = 1'b1;
        #1;
        m_reset();
        chk("rnd_rst_pc", PCSrc, 0);
        @(posedge clk); #1;
        chk("rnd_rst_err", MemErr, 0);
        chk("rnd_rst_rdat", MW_ReadData, 0);
        reset = 1'b0;
      end
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
             {$urandom, $urandom}, a, {$urandom, $urandom});
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
